// File: rtl/mc_control_if.sv
// Control-to-datapath bundle for the multicycle MIPS controller.
// The master side is the controller; the slave side is the datapath or the memory side.
interface mc_control_if;
    logic [31:0] instru;
    logic        zero;
    logic        mem_ready;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ALUSrc;
    logic [3:0]  ALUcontrol;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        reg_write;
    logic        illegal;
    logic        bus_err;
    logic [3:0]  state;

    modport master (
        input  instru, zero, mem_ready,
        output ir_write, pc_write, pc_src, i_or_d, mem_read, mem_write,
               ALUSrc, ALUcontrol, reg_dst, mem_to_reg, reg_write,
               illegal, bus_err, state
    );

    modport slave (
        output instru, zero, mem_ready,
        input  ir_write, pc_write, pc_src, i_or_d, mem_read, mem_write,
               ALUSrc, ALUcontrol, reg_dst, mem_to_reg, reg_write,
               illegal, bus_err, state
    );
endinterface

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing
// with a variable-latency memory handshake, illegal-opcode trap and bus timeout.
module mc_control #(
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input logic          clk,
    input logic          reset,
    mc_control_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_ILLEGAL  = 4'd14,
        S_BUSERR   = 4'd15
    } state_e;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [5:0]    op, fn;
    logic          r_ok;
    logic [3:0]    r_alu, i_alu;
    logic          waiting, timed_out;
    logic          unused_instru;

    assign op            = bus.instru[31:26];
    assign fn            = bus.instru[5:0];
    assign unused_instru = ^bus.instru[25:6];

    always_comb begin
        r_ok  = 1'b1;
        r_alu = ALU_ADD;
        case (fn)
            6'h20:   r_alu = ALU_ADD;
            6'h22:   r_alu = ALU_SUB;
            6'h24:   r_alu = ALU_AND;
            6'h25:   r_alu = ALU_OR;
            6'h27:   r_alu = ALU_NOR;
            6'h2A:   r_alu = ALU_SLT;
            default: r_ok  = 1'b0;
        endcase
    end

    always_comb begin
        case (op)
            6'h0C:   i_alu = ALU_AND;
            6'h0D:   i_alu = ALU_OR;
            6'h0A:   i_alu = ALU_SLT;
            default: i_alu = ALU_ADD;
        endcase
    end

    // A ready in the last allowed cycle still completes the access.
    assign waiting   = state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR};
    assign timed_out = (TIMEOUT != 0) && waiting && !bus.mem_ready && (cnt_q == CNT_LAST);

    always_comb begin
        state_d        = state_q;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 2'b00;
        bus.i_or_d     = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ALUSrc     = 1'b0;
        bus.ALUcontrol = ALU_ADD;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        // Reset masks every strobe so an abandoned instruction cannot write.
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    bus.mem_read = 1'b1;
                    if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        state_d      = S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (op)
                        6'h00:                      state_d = r_ok ? S_EXEC_R : S_ILLEGAL;
                        6'h23, 6'h2B:               state_d = S_MEM_ADDR;
                        6'h04:                      state_d = S_BRANCH;
                        6'h08, 6'h0C, 6'h0D, 6'h0A: state_d = S_EXEC_I;
                        6'h02:                      state_d = S_JUMP;
                        default:                    state_d = S_ILLEGAL;
                    endcase
                end
                S_EXEC_R: begin
                    bus.ALUcontrol = r_alu;
                    state_d        = S_WB_R;
                end
                S_WB_R: begin
                    bus.ALUcontrol = r_alu;
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = 1'b1;
                    state_d        = S_FETCH;
                end
                S_EXEC_I: begin
                    bus.ALUSrc     = 1'b1;
                    bus.ALUcontrol = i_alu;
                    state_d        = S_WB_I;
                end
                S_WB_I: begin
                    bus.ALUSrc     = 1'b1;
                    bus.ALUcontrol = i_alu;
                    bus.reg_write  = 1'b1;
                    state_d        = S_FETCH;
                end
                S_MEM_ADDR: begin
                    bus.ALUSrc = 1'b1;
                    state_d    = (op == 6'h2B) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    bus.ALUSrc   = 1'b1;
                    bus.mem_read = 1'b1;
                    bus.i_or_d   = 1'b1;
                    if (bus.mem_ready) state_d = S_MEM_WB;
                end
                S_MEM_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                    state_d        = S_FETCH;
                end
                S_MEM_WR: begin
                    bus.ALUSrc    = 1'b1;
                    bus.mem_write = 1'b1;
                    bus.i_or_d    = 1'b1;
                    if (bus.mem_ready) state_d = S_FETCH;
                end
                S_BRANCH: begin
                    bus.ALUcontrol = ALU_SUB;
                    bus.pc_src     = 2'b01;
                    bus.pc_write   = bus.zero;
                    state_d        = S_FETCH;
                end
                S_JUMP: begin
                    bus.pc_write = 1'b1;
                    bus.pc_src   = 2'b10;
                    state_d      = S_FETCH;
                end
                S_ILLEGAL: state_d = S_ILLEGAL;
                S_BUSERR:  state_d = S_BUSERR;
                default:   state_d = S_ILLEGAL;
            endcase
            if (timed_out) state_d = S_BUSERR;
        end
    end

    always_comb begin
        if (state_d != state_q)
            cnt_d = '0;
        else if (waiting && !bus.mem_ready)
            cnt_d = cnt_q + 1'b1;
        else
            cnt_d = cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.state   = state_q;
    assign bus.illegal = (state_q == S_ILLEGAL);
    assign bus.bus_err = (state_q == S_BUSERR);
endmodule

// File: tb/tb_mc_control.sv
// Cycle-by-cycle scoreboard bench for mc_control: per-cycle stimulus and the
// expected output vector are queued together and compared at the falling edge.
module tb_mc_control;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   fails  = 0;

    mc_control_if bus ();
    mc_control #(.TIMEOUT(16), .TW(5)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [34:0] stim_q[$];
    logic [20:0] exp_q[$];

    function automatic logic [20:0] ex(input logic [3:0] st, input logic irw, input logic pcw,
                                       input logic [1:0] pcs, input logic iod, input logic mr,
                                       input logic mw, input logic as, input logic [3:0] ac,
                                       input logic rd, input logic m2r, input logic rw,
                                       input logic ill, input logic be);
        return {st, irw, pcw, pcs, iod, mr, mw, as, ac, rd, m2r, rw, ill, be};
    endfunction

    function automatic logic [20:0] obs();
        return {bus.state, bus.ir_write, bus.pc_write, bus.pc_src, bus.i_or_d, bus.mem_read,
                bus.mem_write, bus.ALUSrc, bus.ALUcontrol, bus.reg_dst, bus.mem_to_reg,
                bus.reg_write, bus.illegal, bus.bus_err};
    endfunction

    function automatic logic [20:0] e_rst();  return ex(0,0,0,2'b00,0,0,0,0,4'b0010,0,0,0,0,0); endfunction
    function automatic logic [20:0] e_frdy(); return ex(0,1,1,2'b00,0,1,0,0,4'b0010,0,0,0,0,0); endfunction
    function automatic logic [20:0] e_fwt();  return ex(0,0,0,2'b00,0,1,0,0,4'b0010,0,0,0,0,0); endfunction
    function automatic logic [20:0] e_dec();  return ex(1,0,0,2'b00,0,0,0,0,4'b0010,0,0,0,0,0); endfunction
    function automatic logic [20:0] e_ma();   return ex(6,0,0,2'b00,0,0,0,1,4'b0010,0,0,0,0,0); endfunction
    function automatic logic [20:0] e_mrd();  return ex(7,0,0,2'b00,1,1,0,1,4'b0010,0,0,0,0,0); endfunction
    function automatic logic [20:0] e_mwb();  return ex(8,0,0,2'b00,0,0,0,0,4'b0010,0,1,1,0,0); endfunction
    function automatic logic [20:0] e_mwr();  return ex(9,0,0,2'b00,1,0,1,1,4'b0010,0,0,0,0,0); endfunction
    function automatic logic [20:0] e_ill();  return ex(14,0,0,2'b00,0,0,0,0,4'b0010,0,0,0,1,0); endfunction
    function automatic logic [20:0] e_be();   return ex(15,0,0,2'b00,0,0,0,0,4'b0010,0,0,0,0,1); endfunction

    task automatic push(input logic r, input logic mr, input logic z, input logic [31:0] ins,
                        input logic [20:0] e);
        stim_q.push_back({r, mr, z, ins});
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        int n = 0;
        logic [34:0] s;
        logic [20:0] e, g;
        push(1, 1, 0, 32'h00221820, e_rst());
        push(0, 1, 0, 32'h00221820, e_frdy());
        push(0, 0, 0, 32'h00221820, e_dec());
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front();
            reset = s[34]; bus.mem_ready = s[33]; bus.zero = s[32]; bus.instru = s[31:0];
            @(negedge clk);
            g = obs(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin fails++; $display("FAIL reset cyc%0d got %h expected %h", n, g, e); end
            n++; @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype();
        int n = 0;
        logic [34:0] s;
        logic [20:0] e, g;
        logic [5:0] fns[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
        logic [3:0] acs[6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};
        push(1, 0, 0, 32'h0, e_rst());
        for (int i = 0; i < 6; i++) begin
            logic [31:0] ins;
            ins = 32'h00221800 | {26'h0, fns[i]};
            push(0, 1, 0, ins, e_frdy());
            push(0, 1, 1, ins, e_dec());
            push(0, 1, 1, ins, ex(2,0,0,2'b00,0,0,0,0,acs[i],0,0,0,0,0));
            push(0, 1, 0, ins, ex(3,0,0,2'b00,0,0,0,0,acs[i],1,0,1,0,0));
        end
        push(0, 0, 0, 32'h0, e_fwt());
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front();
            reset = s[34]; bus.mem_ready = s[33]; bus.zero = s[32]; bus.instru = s[31:0];
            @(negedge clk);
            g = obs(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin fails++; $display("FAIL rtype cyc%0d got %h expected %h", n, g, e); end
            n++; @(posedge clk); #1;
        end
    endtask

    task automatic test_itype();
        int n = 0;
        logic [34:0] s;
        logic [20:0] e, g;
        logic [5:0] ops[4] = '{6'h08, 6'h0C, 6'h0D, 6'h0A};
        logic [3:0] acs[4] = '{4'b0010, 4'b0000, 4'b0001, 4'b0111};
        push(1, 0, 0, 32'h0, e_rst());
        for (int i = 0; i < 4; i++) begin
            logic [31:0] ins;
            ins = {ops[i], 26'h0220005};
            push(0, 1, 0, ins, e_frdy());
            push(0, 0, 0, ins, e_dec());
            push(0, 0, 0, ins, ex(4,0,0,2'b00,0,0,0,1,acs[i],0,0,0,0,0));
            push(0, 0, 0, ins, ex(5,0,0,2'b00,0,0,0,1,acs[i],0,0,1,0,0));
        end
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front();
            reset = s[34]; bus.mem_ready = s[33]; bus.zero = s[32]; bus.instru = s[31:0];
            @(negedge clk);
            g = obs(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin fails++; $display("FAIL itype cyc%0d got %h expected %h", n, g, e); end
            n++; @(posedge clk); #1;
        end
    endtask

    // lw with a three-cycle stall, then sw with a one-cycle stall, then j.
    task automatic test_mem_jump();
        int n = 0;
        logic [34:0] s;
        logic [20:0] e, g;
        push(1, 0, 0, 32'h0, e_rst());
        push(0, 1, 0, 32'h8C220004, e_frdy());
        push(0, 1, 0, 32'h8C220004, e_dec());
        push(0, 1, 0, 32'h8C220004, e_ma());
        push(0, 0, 0, 32'h8C220004, e_mrd());
        push(0, 0, 0, 32'h8C220004, e_mrd());
        push(0, 0, 0, 32'h8C220004, e_mrd());
        push(0, 1, 0, 32'h8C220004, e_mrd());
        push(0, 1, 0, 32'h8C220004, e_mwb());
        push(0, 1, 0, 32'hAC220004, e_frdy());
        push(0, 0, 0, 32'hAC220004, e_dec());
        push(0, 0, 0, 32'hAC220004, e_ma());
        push(0, 0, 0, 32'hAC220004, e_mwr());
        push(0, 1, 0, 32'hAC220004, e_mwr());
        push(0, 1, 0, 32'h08000010, e_frdy());
        push(0, 1, 0, 32'h08000010, e_dec());
        push(0, 1, 0, 32'h08000010, ex(11,0,1,2'b10,0,0,0,0,4'b0010,0,0,0,0,0));
        push(0, 0, 0, 32'h08000010, e_fwt());
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front();
            reset = s[34]; bus.mem_ready = s[33]; bus.zero = s[32]; bus.instru = s[31:0];
            @(negedge clk);
            g = obs(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin fails++; $display("FAIL memjump cyc%0d got %h expected %h", n, g, e); end
            n++; @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        int n = 0;
        logic [34:0] s;
        logic [20:0] e, g;
        push(1, 0, 0, 32'h0, e_rst());
        for (int z = 1; z >= 0; z--) begin
            push(0, 1, 1'(z), 32'h10220003, e_frdy());
            push(0, 1, 1'(z), 32'h10220003, e_dec());
            push(0, 1, 1'(z), 32'h10220003, ex(10,0,1'(z),2'b01,0,0,0,0,4'b0110,0,0,0,0,0));
        end
        push(0, 0, 0, 32'h10220003, e_fwt());
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front();
            reset = s[34]; bus.mem_ready = s[33]; bus.zero = s[32]; bus.instru = s[31:0];
            @(negedge clk);
            g = obs(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin fails++; $display("FAIL branch cyc%0d got %h expected %h", n, g, e); end
            n++; @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        int n = 0;
        logic [34:0] s;
        logic [20:0] e, g;
        logic [31:0] bad[2] = '{32'hFC000000, 32'h00000008};
        for (int k = 0; k < 2; k++) begin
            push(1, 0, 0, bad[k], e_rst());
            push(0, 1, 0, bad[k], e_frdy());
            push(0, 1, 0, bad[k], e_dec());
            for (int c = 0; c < 20; c++) push(0, 1'($urandom_range(0, 1)), 1'(c), bad[k], e_ill());
        end
        push(1, 0, 0, 32'h0, e_rst());
        push(0, 0, 0, 32'h0, e_fwt());
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front();
            reset = s[34]; bus.mem_ready = s[33]; bus.zero = s[32]; bus.instru = s[31:0];
            @(negedge clk);
            g = obs(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin fails++; $display("FAIL illegal cyc%0d got %h expected %h", n, g, e); end
            n++; @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        logic [34:0] s;
        logic [20:0] e, g;
        push(1, 0, 0, 32'h00221820, e_rst());
        for (int c = 0; c < 16; c++) push(0, 0, 0, 32'h00221820, e_fwt());
        for (int c = 0; c < 3; c++)  push(0, 1, 0, 32'h00221820, e_be());
        push(1, 0, 0, 32'h00221820, e_rst());
        for (int c = 0; c < 15; c++) push(0, 0, 0, 32'h00221820, e_fwt());
        push(0, 1, 0, 32'h00221820, e_frdy());
        push(0, 0, 0, 32'h00221820, e_dec());
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front();
            reset = s[34]; bus.mem_ready = s[33]; bus.zero = s[32]; bus.instru = s[31:0];
            @(negedge clk);
            g = obs(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin fails++; $display("FAIL timeout cyc%0d got %h expected %h", n, g, e); end
            n++; @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_midwr();
        int n = 0;
        logic [34:0] s;
        logic [20:0] e, g;
        push(1, 0, 0, 32'hAC220004, e_rst());
        push(0, 1, 0, 32'hAC220004, e_frdy());
        push(0, 0, 0, 32'hAC220004, e_dec());
        push(0, 0, 0, 32'hAC220004, e_ma());
        push(0, 0, 0, 32'hAC220004, e_mwr());
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front();
            reset = s[34]; bus.mem_ready = s[33]; bus.zero = s[32]; bus.instru = s[31:0];
            @(negedge clk);
            g = obs(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin fails++; $display("FAIL midwr cyc%0d got %h expected %h", n, g, e); end
            n++; @(posedge clk); #1;
        end
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (bus.mem_write !== 1'b1) begin
            fails++; $display("FAIL midwr_pre got mem_write=%b expected 1", bus.mem_write);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.mem_write, bus.state} !== 5'b0) begin
            fails++; $display("FAIL midwr_drop got mem_write=%b state=%0d expected 0/0", bus.mem_write, bus.state);
        end
        @(posedge clk); #1;
        push(0, 1, 0, 32'h00221820, e_frdy());
        push(0, 0, 0, 32'h00221820, e_dec());
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front();
            reset = s[34]; bus.mem_ready = s[33]; bus.zero = s[32]; bus.instru = s[31:0];
            @(negedge clk);
            g = obs(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin fails++; $display("FAIL midwr_after cyc%0d got %h expected %h", n, g, e); end
            n++; @(posedge clk); #1;
        end
    endtask

    initial begin
        bus.instru    = 32'h0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_rtype();
        test_itype();
        test_mem_jump();
        test_branch();
        test_illegal();
        test_timeout();
        test_reset_midwr();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
